// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: ALU op codes,
// muldiv operation encoding and FSM state type.
package muldiv_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSVD = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_DIV_CMP = 3'd2,
    S_DIV_SUB = 3'd3,
    S_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MUL/DIVU/REMU unit borrowing an external shared ALU.
// Divide support is compiled in only when MULDIV_SEQ_DIV_EN is defined.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
`ifdef MULDIV_SEQ_DIV_EN
  muldiv_op_e  op_q, op_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] divisor_q, divisor_d;
  logic        ovf_q, ovf_d;
  logic        lt_q, lt_d;
`endif

  // ALU operands are decoded from state so the shared ALU idles at ADD 0,0
  always_comb begin
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_ctrl_o = ALU_ADD;
    case (state_q)
      S_MUL: begin
        alu_a_o = acc_q;
        alu_b_o = mplier_q[0] ? mcand_q : '0;
      end
`ifdef MULDIV_SEQ_DIV_EN
      S_DIV_CMP: begin
        alu_a_o    = {rem_q[30:0], quot_q[31]};
        alu_b_o    = divisor_q;
        alu_ctrl_o = ALU_SLTU;
      end
      S_DIV_SUB: begin
        // rem_q already holds the shifted remainder captured in DIV_CMP
        alu_a_o    = rem_q;
        alu_b_o    = divisor_q;
        alu_ctrl_o = ALU_SUB;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef MULDIV_SEQ_DIV_EN
    op_d      = op_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    ovf_d     = ovf_q;
    lt_d      = lt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d  = '0;
          busy_d = 1'b1;
`ifdef MULDIV_SEQ_DIV_EN
          op_d   = muldiv_op_e'(op_i);
`endif
          case (op_i)
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = rs1_i;
              mplier_d = rs2_i;
              state_d  = S_MUL;
            end
`ifdef MULDIV_SEQ_DIV_EN
            OP_DIVU, OP_REMU: begin
              if (rs2_i != '0) begin
                rem_d     = '0;
                quot_d    = rs1_i;
                divisor_d = rs2_i;
                state_d   = S_DIV_CMP;
              end else begin
                state_d  = S_DONE;
                done_d   = 1'b1;
                result_d = (op_i == OP_DIVU) ? 32'hFFFF_FFFF : rs1_i;
              end
            end
`endif
            default: begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              result_d = '0;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = alu_result_i;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = alu_result_i;
        end
      end
`ifdef MULDIV_SEQ_DIV_EN
      S_DIV_CMP: begin
        rem_d   = {rem_q[30:0], quot_q[31]};
        ovf_d   = rem_q[31];
        quot_d  = quot_q << 1;
        lt_d    = alu_result_i[0];
        state_d = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        // A bit shifted out of rem means the true remainder exceeds any divisor
        if (ovf_q || !lt_q) begin
          rem_d     = alu_result_i;
          quot_d[0] = 1'b1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = (op_q == OP_DIVU) ? quot_d : rem_d;
        end else begin
          state_d = S_DIV_CMP;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
`ifdef MULDIV_SEQ_DIV_EN
    op_q      <= op_d;
    rem_q     <= rem_d;
    quot_q    <= quot_d;
    divisor_q <= divisor_d;
    ovf_q     <= ovf_d;
    lt_q      <= lt_d;
`endif
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, corner sequences and random ops
// against an arithmetic reference; honours MULDIV_SEQ_DIV_EN like the design.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        busy_o, done_o;
  logic [31:0] result_o, alu_a_o, alu_b_o, alu_result_i;
  logic [3:0]  alu_ctrl_o;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_result_i(alu_result_i)
  );

  always #5 clk = ~clk;

  // Shared ALU seen by the unit
  always_comb begin
    alu_result_i = '0;
    case (alu_ctrl_o)
      4'd0: alu_result_i = alu_a_o + alu_b_o;
      4'd1: alu_result_i = alu_a_o - alu_b_o;
      4'd5: alu_result_i = {31'b0, (alu_a_o < alu_b_o)};
      default: alu_result_i = '0;
    endcase
  end

`ifdef MULDIV_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  function automatic logic [31:0] ref_res(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (op == 2'd0) return p[31:0];
    if (!DIV_EN || op == 2'd3) return 32'h0;
    if (op == 2'd1) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int ref_lat(logic [1:0] op, logic [31:0] b);
    if (op == 2'd0) return 33;
    if (DIV_EN && (op == 2'd1 || op == 2'd2) && b != 0) return 65;
    return 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE and follow it to completion
  task automatic run_op(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp_res, int exp_lat);
    int cyc;
    int lat;
    bit busy_ok;
    logic [31:0] res;
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    lat = -1; busy_ok = 1'b1; res = '0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (done_o === 1'b1) begin
        lat = cyc;
        res = result_o;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, res, exp_res);
    check({name, " busy"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    check({name, " idle busy/done"}, {30'b0, busy_o, done_o}, 32'd0);
    check({name, " idle alu"}, alu_a_o | alu_b_o | {28'b0, alu_ctrl_o}, 32'd0);
    check({name, " held"}, result_o, exp_res);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    vecs[0] = '{"mul7x6",   2'd0, 32'd7,          32'd6,          32'd42,         33};
    vecs[1] = '{"mulmax",   2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33};
    vecs[2] = '{"mulwrap",  2'd0, 32'h0001_0000,  32'h0001_0000,  32'd0,          33};
    vecs[9] = '{"rsvd",     2'd3, 32'd9,          32'd4,          32'd0,          1};
`ifdef MULDIV_SEQ_DIV_EN
    vecs[3] = '{"divu100_7", 2'd1, 32'd100,        32'd7,          32'd14,         65};
    vecs[4] = '{"remu100_7", 2'd2, 32'd100,        32'd7,          32'd2,          65};
    vecs[5] = '{"divu_ovf",  2'd1, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          65};
    vecs[6] = '{"remu_ovf",  2'd2, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  65};
    vecs[7] = '{"divu_z",    2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[8] = '{"remu_z",    2'd2, 32'd5,          32'd0,          32'd5,          1};
`else
    vecs[3] = '{"divu100_7", 2'd1, 32'd100,        32'd7,          32'd0,          1};
    vecs[4] = '{"remu100_7", 2'd2, 32'd100,        32'd7,          32'd0,          1};
    vecs[5] = '{"divu_ovf",  2'd1, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1};
    vecs[6] = '{"remu_ovf",  2'd2, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1};
    vecs[7] = '{"divu_z",    2'd1, 32'd5,          32'd0,          32'd0,          1};
    vecs[8] = '{"remu_z",    2'd2, 32'd5,          32'd0,          32'd0,          1};
`endif

    repeat (3) @(negedge clk);
    check("reset busy/done", {30'b0, busy_o, done_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset alu", alu_a_o | alu_b_o | {28'b0, alu_ctrl_o}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // Starts during MUL and in DONE must be dropped
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd0; rs1_i = 32'd7; rs2_i = 32'd6;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 33) begin
        check("ign done", {31'b0, done_o}, 32'd1);
        check("ign result", result_o, 32'd42);
      end
      if (c == 32) check("ign no early done", {31'b0, done_o}, 32'd0);
      if (c >= 34) check($sformatf("ign idle c%0d", c), {31'b0, busy_o}, 32'd0);
      start_i = (c == 5 || c == 33);
      rs1_i = 32'd3; rs2_i = 32'd3;
    end
    start_i = 1'b0;

    // Reset in cycle 10 of a MUL
    @(negedge clk);
    start_i = 1'b1; op_i = 2'd0; rs1_i = 32'd11; rs2_i = 32'd13;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("pre-rst busy", {31'b0, busy_o}, 32'd1);
    check("pre-rst result", result_o, 32'd42);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst busy/done", {30'b0, busy_o, done_o}, 32'd0);
    check("mid rst result", result_o, 32'd0);
    check("mid rst alu", alu_a_o | alu_b_o | {28'b0, alu_ctrl_o}, 32'd0);

    // rst wins over a simultaneous start
    rst = 1'b1; start_i = 1'b1; op_i = 2'd0; rs1_i = 32'd2; rs2_i = 32'd2;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    check("rst prio busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    check("rst prio stays idle", {31'b0, busy_o}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d op%0d", n, op), op, a, b, ref_res(op, a, b), ref_lat(op, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start_i, input, 1 bit: request; sampled only in IDLE.
REQ-004 SHALL have port op_i, input, 2 bits: 00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved.
REQ-005 SHALL have ports rs1_i and rs2_i, inputs, 32 bits each: operands, captured when start is accepted.
REQ-006 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done_o, output, 1 bit: one-cycle pulse in DONE.
REQ-008 SHALL have port result_o, output, 32 bits: result, valid from DONE and held until the next accepted start.
REQ-009 SHALL have ports alu_a_o and alu_b_o, outputs, 32 bits each: operands to the shared ALU.
REQ-010 SHALL have port alu_ctrl_o, output, 4 bits: shared ALU op code (ADD=0, SUB=1, SLTU=5).
REQ-011 SHALL have port alu_result_i, input, 32 bits: combinational ALU result, same cycle.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV_CMP, DIV_SUB and DONE, plus a 5-bit iteration counter.
REQ-013 IDLE + start_i: SHALL latch operands, clear the counter and branch by op.
  - MUL -> MUL.
  - DIVU/REMU, rs2_i!=0 -> DIV_CMP.
  - Otherwise -> DONE.
REQ-014 MUL, one cycle per bit, 32 cycles:
  - ALU drive: a=acc, b=(mplier[0] ? mcand : 0), ctrl=ADD.
  - Register update: acc<=alu_result_i, mcand<<=1, mplier>>=1.
  - After count 31, go to DONE.
REQ-015 DIV_CMP, per bit:
  - Form rem'={rem[30:0],quot[31]} and ovf=rem[31]; shift quot left by 1.
  - ALU drive: a=rem', b=divisor, ctrl=SLTU; latch lt=alu_result_i[0].
  - Go to DIV_SUB.
REQ-016 DIV_SUB:
  - ALU drive: a=rem', b=divisor, ctrl=SUB.
  - If (ovf | ~lt): rem<=alu_result_i and quot[0]<=1; else rem<=rem'.
  - After count 31, go to DONE; else go to DIV_CMP.
REQ-017 Latency, counting the accept cycle as cycle 0:
  - MUL: done_o in cycle 33.
  - DIVU/REMU: done_o in cycle 65.
  - Divide-by-zero or reserved op: done_o in cycle 1.
REQ-018 Results:
  - MUL: acc.
  - DIVU: quot.
  - REMU: rem.
  - Divide by zero: DIVU 0xFFFFFFFF, REMU rs1.
  - Reserved op: 0.
REQ-019 DONE SHALL return to IDLE unconditionally; start_i in DONE or while busy SHALL be ignored and not queued.
REQ-020 In IDLE and DONE, alu_a_o, alu_b_o and alu_ctrl_o SHALL be 0, so the shared ALU sees ADD 0,0.
REQ-021 All arithmetic is unsigned 32-bit: ADD carries are discarded and SUB wraps modulo 2^32.

Reset
REQ-022 rst high at a clock edge SHALL force IDLE, counter=0, busy_o=0, done_o=0, result_o=0 and ALU outputs=0, including mid-operation.
REQ-023 Reset priority: rst SHALL take priority over start_i in the same cycle.

Configuration
REQ-024 Macro MULDIV_SEQ_DIV_EN:
  - Defined: DIVU/REMU behave as specified above.
  - Undefined: DIV_CMP and DIV_SUB are compiled out, and ops 01/10 behave as reserved (result 0, done_o in cycle 1).

Structure
REQ-025 A shared package SHALL hold:
  - the ALU op-code constants (ADD, SUB, SLTU, and the others used by the ALU);
  - the muldiv op enum;
  - the FSM state typedef.
REQ-026 No sub-module SHALL be instantiated; the ALU lives outside this block and is shared through the alu_* ports.

Verification
REQ-027 MUL 7*6 -> result_o=42, done_o high in cycle 33 only, busy_o high cycles 1..33.
REQ-028 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MUL 0x00010000*0x00010000 -> 0x00000000.
REQ-029 DIVU 100/7 -> 14 and REMU 100/7 -> 2, done_o in cycle 65.
REQ-030 DIVU 0xFFFFFFFF/0x80000000 -> 1 and REMU -> 0x7FFFFFFF (overflow path).
REQ-031 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with done_o in cycle 1; op 11 -> 0 in cycle 1.
REQ-032 Reset mid-operation and busy start:
  - rst in cycle 10 of a MUL -> busy_o=0 and result_o=0 next cycle.
  - start_i pulsed in cycles 5 and 33 of a MUL -> ignored.
